// File: rtl/switch_priority_encoder_4_2_pkg.sv
// ---------------------------------------------------------------------------
// switch_priority_encoder_4_2_pkg
//   Shared types and helpers for the switch priority encoder.
//   - state_e   : debounce FSM states (ST_STABLE / ST_SETTLE)
//   - enc_t     : {valid, code[1:0]} result, same bit layout as the LEDs and
//                 the layout the 2-to-4 decoder consumes
//   - prio_enc4 : 4-bit vector -> {valid, code}, bit 3 highest priority
// ---------------------------------------------------------------------------
package switch_priority_encoder_4_2_pkg;

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_SETTLE = 1'b1
    } state_e;

    typedef struct packed {
        logic       valid;
        logic [1:0] code;
    } enc_t;

    function automatic enc_t prio_enc4(input logic [3:0] v);
        enc_t r;
        r.valid = |v;
        if (v[3])      r.code = 2'd3;
        else if (v[2]) r.code = 2'd2;
        else if (v[1]) r.code = 2'd1;
        else           r.code = 2'd0;
        return r;
    endfunction

endpackage

// File: rtl/switch_priority_encoder_4_2_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchronizer for a vector of asynchronous inputs. All bits are
//   sampled together; no attempt is made to align per-bit skew (the debounce
//   stage downstream absorbs it).
// Ports:
//   clk   in  1      rising-edge clock
//   reset in  1      synchronous, active-high; clears both stages
//   d     in  WIDTH  asynchronous inputs
//   q     out WIDTH  synchronized outputs (second stage)
// ---------------------------------------------------------------------------
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= d;
            sync2_q <= sync1_q;
        end
    end

    assign q = sync2_q;

endmodule

// File: rtl/switch_priority_encoder_4_2.sv
// ---------------------------------------------------------------------------
// switch_priority_encoder_4_2
//   Board-input side of the 2-to-4 decoder lab pair. Four raw slide switches
//   are synchronized, debounced as a whole vector, priority encoded into
//   {valid, code} and registered. A one-cycle strobe marks every change of the
//   encoded result.
// Ports:
//   clk      in  1  rising-edge clock
//   reset    in  1  synchronous, active-high; clears all state
//   switches in  4  raw asynchronous switches, bit 3 highest priority
//   code     out 2  index of highest committed set switch (00 when none)
//   valid    out 1  any committed switch set
//   changed  out 1  pulse in the first cycle a new {valid,code} is shown
//   lights   out 3  {valid, code}
// Latency: a new steady input first sampled on edge 1 commits to the stable
//   vector at edge N+3 and appears on the outputs at edge N+4.
// ---------------------------------------------------------------------------
module switch_priority_encoder_4_2
    import switch_priority_encoder_4_2_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] switches,
    output logic [1:0] code,
    output logic       valid,
    output logic       changed,
    output logic [2:0] lights
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       sync2;

    state_e           state_q, state_d;
    logic [3:0]       cand_q, cand_d;
    logic [3:0]       stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    enc_t             enc_q, enc_d;
    logic             changed_q, changed_d;

    sync_2ff #(.WIDTH(4)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (switches),
        .q     (sync2)
    );

    // Debounce FSM: a candidate must be seen unchanged for DEBOUNCE_CYCLES
    // consecutive samples before it replaces the stable vector. Any change
    // restarts the count; a return to the old stable value abandons it.
    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            ST_STABLE: begin
                if (sync2 != stable_q) begin
                    cand_d  = sync2;
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (sync2 != cand_q) begin
                    cand_d = sync2;
                    cnt_d  = '0;
                end else if (cand_q == stable_q) begin
                    state_d = ST_STABLE;
                end else if (cnt_q == CNT_MAX) begin
                    stable_d = cand_q;
                    state_d  = ST_STABLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_STABLE;
        endcase
    end

    // Encode one cycle behind the stable vector; the strobe compares the
    // encoded value, so commits that keep the same code stay silent.
    always_comb begin
        enc_d     = prio_enc4(stable_q);
        changed_d = (enc_d != enc_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_STABLE;
            cand_q    <= '0;
            stable_q  <= '0;
            cnt_q     <= '0;
            enc_q     <= '0;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
            enc_q     <= enc_d;
            changed_q <= changed_d;
        end
    end

    assign code    = enc_q.code;
    assign valid   = enc_q.valid;
    assign lights  = enc_q;
    assign changed = changed_q;

endmodule

// File: tb/tb_switch_priority_encoder_4_2.sv
module tb_switch_priority_encoder_4_2;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] switches;
    logic [1:0] code;
    logic       valid;
    logic       changed;
    logic [2:0] lights;

    int checks = 0;
    int errors = 0;

    logic [2:0] exp_tbl [16];

    switch_priority_encoder_4_2 #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W(20)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .switches (switches),
        .code     (code),
        .valid    (valid),
        .changed  (changed),
        .lights   (lights)
    );

    always #5 clk = ~clk;

    // advance n rising edges, then settle 1 time unit before sampling
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // hold current switches for n edges, checking that no strobe appears
    // and the lights stay at the given value
    task automatic quiet(input int n, input logic [2:0] lt, input string tag);
        for (int i = 0; i < n; i++) begin
            tick(1);
            chk({tag, "_changed"}, {3'b0, changed}, 4'h0);
            chk({tag, "_lights"}, {1'b0, lights}, {1'b0, lt});
        end
    endtask

    initial begin
        // hand-computed {valid,code} for every switch value
        exp_tbl[0]  = 3'b000; exp_tbl[1]  = 3'b100;
        exp_tbl[2]  = 3'b101; exp_tbl[3]  = 3'b101;
        exp_tbl[4]  = 3'b110; exp_tbl[5]  = 3'b110;
        exp_tbl[6]  = 3'b110; exp_tbl[7]  = 3'b110;
        for (int i = 8; i < 16; i++) exp_tbl[i] = 3'b111;

        // reset
        reset    = 1'b1;
        switches = 4'b0000;
        tick(2);
        chk("rst_lights",  {1'b0, lights}, 4'h0);
        chk("rst_code",    {2'b0, code},   4'h0);
        chk("rst_valid",   {3'b0, valid},  4'h0);
        chk("rst_changed", {3'b0, changed}, 4'h0);
        reset = 1'b0;
        quiet(10, 3'b000, "post_rst");

        // 0000 -> 0100: new value on edge 8, single pulse
        switches = 4'b0100;
        quiet(7, 3'b000, "s0100_wait");
        tick(1);
        chk("s0100_code",    {2'b0, code},   4'h2);
        chk("s0100_valid",   {3'b0, valid},  4'h1);
        chk("s0100_lights",  {1'b0, lights}, 4'h6);
        chk("s0100_changed", {3'b0, changed}, 4'h1);
        tick(1);
        chk("s0100_pulse_end", {3'b0, changed}, 4'h0);

        // 0100 -> 0110: same code, no pulse
        switches = 4'b0110;
        quiet(14, 3'b110, "s0110_same");

        // 0110 -> 1001
        switches = 4'b1001;
        quiet(7, 3'b110, "s1001_wait");
        tick(1);
        chk("s1001_lights",  {1'b0, lights}, 4'h7);
        chk("s1001_changed", {3'b0, changed}, 4'h1);
        tick(1);
        chk("s1001_pulse_end", {3'b0, changed}, 4'h0);

        // back to all zero: valid drops
        switches = 4'b0000;
        tick(8);
        chk("s0000_lights",  {1'b0, lights}, 4'h0);
        chk("s0000_changed", {3'b0, changed}, 4'h1);
        tick(1);
        chk("s0000_pulse_end", {3'b0, changed}, 4'h0);

        // short bounce back to old value: nothing happens
        switches = 4'b0001;
        tick(2);
        switches = 4'b0000;
        quiet(15, 3'b000, "bounce");

        // toggle every 3 cycles, then hold 0001
        for (int t = 0; t < 6; t++) begin
            switches = (t % 2 == 0) ? 4'b0001 : 4'b0000;
            quiet(3, 3'b000, "toggle");
        end
        switches = 4'b0001;
        quiet(7, 3'b000, "hold_wait");
        tick(1);
        chk("hold_lights",  {1'b0, lights}, 4'h4);
        chk("hold_changed", {3'b0, changed}, 4'h1);
        tick(1);
        chk("hold_pulse_end", {3'b0, changed}, 4'h0);

        // reset while settling on 1000
        switches = 4'b1000;
        tick(4);
        reset = 1'b1;
        tick(1);
        chk("midrst_lights",  {1'b0, lights}, 4'h0);
        chk("midrst_code",    {2'b0, code},   4'h0);
        chk("midrst_valid",   {3'b0, valid},  4'h0);
        chk("midrst_changed", {3'b0, changed}, 4'h0);
        reset = 1'b0;
        quiet(7, 3'b000, "relrst_wait");
        tick(1);
        chk("relrst_lights",  {1'b0, lights}, 4'h7);
        chk("relrst_changed", {3'b0, changed}, 4'h1);
        tick(1);
        chk("relrst_pulse_end", {3'b0, changed}, 4'h0);

        // sweep all steady values, with a decoder round-trip check
        for (int v = 0; v < 16; v++) begin
            logic [3:0] sv;
            logic [3:0] dec;
            logic [3:0] above;
            logic       rt_ok;
            sv = 4'(v);
            switches = sv;
            tick(8);
            chk("sweep_enc", {1'b0, valid, code}, {1'b0, exp_tbl[v]});
            dec   = 4'b0001 << code;
            above = ~((dec << 1) - 4'b0001);
            rt_ok = valid ? (((dec & sv) != 4'b0) && ((sv & above) == 4'b0))
                          : (sv == 4'b0 && code == 2'b00);
            chk("sweep_roundtrip", {3'b0, rt_ok}, 4'h1);
            chk("sweep_lights", {1'b0, lights}, {1'b0, exp_tbl[v]});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
